// File: rtl/seq_det_pkg.sv
// Shared encodings and default sizes for the "110" detector scheduler.
package seq_det_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_FRAME_W = 8;
  localparam int DEF_CNT_W   = 4;

endpackage

// File: rtl/seq_det_sched_if.sv
// Requester/response bus between frame requesters and the detector scheduler.
interface seq_det_sched_if
  import seq_det_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*FRAME_W-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [CNT_W-1:0]           rsp_count;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_count
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_count
  );

endinterface

// File: rtl/seq_det_sched_rr_arbiter.sv
// Combinational round-robin arbiter; search starts just above last_grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  // Two passes: indices above the pointer first, then wrap from index 0.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req[i] && (ID_W'(i) > last_grant)) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
  end

  // One-hot form of the winning index.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = gnt_any && (gnt_idx == ID_W'(i));
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one external "110" detector among NUM_REQ frame requesters.
//
// state | meaning
// IDLE  | arbitrate, accept one frame from the round-robin winner
// CLEAR | det_rst high for one cycle so no pattern spans two frames
// SHIFT | FRAME_W cycles serialising the frame MSB-first into the detector
// DRAIN | one zero bit so the hit caused by the last frame bit is counted
// RESP  | hold id/count until rsp_ready
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_det_sched_if.slave bus,
  output logic           det_rst,
  output logic           det_bit,
  input  logic           det_hit
);

  localparam int BIT_W = $clog2(FRAME_W);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic [BIT_W-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [FRAME_W-1:0] gnt_frame;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // Select the frame belonging to the current winner.
  always_comb begin
    gnt_frame = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_frame = bus.req_data[i*FRAME_W +: FRAME_W];
    end
  end

  // Next-state, shift register, bit index and saturating hit counter.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          sreg_d  = gnt_frame;
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        idx_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
        if (idx_q == BIT_W'(FRAME_W - 1)) state_d = ST_DRAIN;
        else                              idx_d   = idx_q + BIT_W'(1);
      end
      ST_DRAIN: state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // det_hit lags det_bit by one cycle, so SHIFT and DRAIN cover every frame bit.
    if ((state_q == ST_SHIFT || state_q == ST_DRAIN) && det_hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset; requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      id_q    <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = {NUM_REQ{rst_n && (state_q == ST_IDLE)}} & gnt;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_count = cnt_q;
  assign det_rst       = !rst_n || (state_q == ST_CLEAR);
  assign det_bit       = (state_q == ST_SHIFT) ? sreg_q[FRAME_W-1] : 1'b0;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched with a behavioural "110" detector model.
module tb_seq_det_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic det_rst, det_bit, det_hit;
  logic det_rst_s, det_bit_s, det_hit_s;
  logic [1:0] hist, hist_s;

  int n_checks = 0;
  int n_err    = 0;

  seq_det_sched_if #(.NUM_REQ(2), .FRAME_W(8), .CNT_W(4), .ID_W(1)) bus ();
  seq_det_sched_if #(.NUM_REQ(2), .FRAME_W(8), .CNT_W(1), .ID_W(1)) bus_s ();

  seq_det_sched #(.NUM_REQ(2), .FRAME_W(8), .CNT_W(4), .ID_W(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .det_rst (det_rst),
    .det_bit (det_bit),
    .det_hit (det_hit)
  );

  seq_det_sched #(.NUM_REQ(2), .FRAME_W(8), .CNT_W(1), .ID_W(1)) dut_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_s),
    .det_rst (det_rst_s),
    .det_bit (det_bit_s),
    .det_hit (det_hit_s)
  );

  // Saturation instance runs in lockstep on the same stimulus.
  assign bus_s.req_valid = bus.req_valid;
  assign bus_s.req_data  = bus.req_data;
  assign bus_s.rsp_ready = bus.rsp_ready;

  // Detector model: registered hit one cycle after the '0' completing "110".
  always_ff @(posedge clk) begin
    if (det_rst) begin
      hist    <= 2'b00;
      det_hit <= 1'b0;
    end else begin
      det_hit <= (hist == 2'b11) && !det_bit;
      hist    <= {hist[0], det_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (det_rst_s) begin
      hist_s    <= 2'b00;
      det_hit_s <= 1'b0;
    end else begin
      det_hit_s <= (hist_s == 2'b11) && !det_bit_s;
      hist_s    <= {hist_s[0], det_bit_s};
    end
  end

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    int         exp_id;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Entered at posedge+1 with inputs driven; returns at posedge+1 of the IDLE cycle after accept.
  task automatic run_frame(input string nm, input int exp_id, input logic [7:0] exp_data,
                           input int exp_cnt, input bit keep, input int stall, output int waited);
    logic [7:0] seen;
    logic       rst_seen;
    seen     = '0;
    rst_seen = 1'b0;
    waited   = 0;
    #1;
    while (bus.req_ready == 2'b00 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) begin
      chk({nm, "_grant_timeout"}, 32'(waited), 0);
      return;
    end
    chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'(1 << exp_id));
    @(posedge clk); #1;
    if (!keep) bus.req_valid = 2'b00;
    #1;
    chk({nm, "_clear_det_rst"}, 32'(det_rst), 1);
    chk({nm, "_clear_ready"}, 32'(bus.req_ready), 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      seen = {seen[6:0], det_bit};
      if (det_rst) rst_seen = 1'b1;
    end
    chk({nm, "_det_bits"}, 32'(seen), 32'(exp_data));
    chk({nm, "_shift_det_rst"}, 32'(rst_seen), 0);
    @(posedge clk); #1;
    chk({nm, "_drain_det_bit"}, 32'(det_bit), 0);
    chk({nm, "_drain_rsp_valid"}, 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
    chk({nm, "_rsp_id"}, 32'(bus.rsp_id), 32'(exp_id));
    chk({nm, "_rsp_count"}, 32'(bus.rsp_count), 32'(exp_cnt));
    chk({nm, "_sat_count"}, 32'(bus_s.rsp_count), (exp_cnt > 0) ? 1 : 0);
    if (stall > 0) begin
      bus.req_valid = 2'b11;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk({nm, "_stall_valid"}, 32'(bus.rsp_valid), 1);
        chk({nm, "_stall_id"}, 32'(bus.rsp_id), 32'(exp_id));
        chk({nm, "_stall_count"}, 32'(bus.rsp_count), 32'(exp_cnt));
        chk({nm, "_stall_ready"}, 32'(bus.req_ready), 0);
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, "_idle_rsp_valid"}, 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int waited;

    vecs[0] = '{2'b01, 8'b1101_1000, 8'h00, 0, 2};
    vecs[1] = '{2'b01, 8'b0000_0011, 8'h00, 0, 0};
    vecs[2] = '{2'b01, 8'b0000_0000, 8'h00, 0, 0};
    vecs[3] = '{2'b10, 8'h00, 8'b0110_0000, 1, 1};
    vecs[4] = '{2'b11, 8'hFF, 8'b0110_0000, 0, 0};
    vecs[5] = '{2'b11, 8'hFF, 8'b0110_0000, 1, 1};
    vecs[6] = '{2'b01, 8'b1011_0110, 8'h00, 0, 2};
    vecs[7] = '{2'b01, 8'b1101_1011, 8'h00, 0, 2};
    vecs[8] = '{2'b10, 8'h00, 8'b0110_1101, 1, 2};

    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_det_rst", 32'(det_rst), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("post_rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("post_rst_rsp_count", 32'(bus.rsp_count), 0);
    chk("post_rst_det_bit", 32'(det_bit), 0);
    chk("post_rst_det_rst", 32'(det_rst), 0);

    for (int v = 0; v < 9; v++) begin
      bus.req_valid = vecs[v].valid;
      bus.req_data  = {vecs[v].d1, vecs[v].d0};
      run_frame($sformatf("vec%0d", v), vecs[v].exp_id,
                (vecs[v].exp_id == 1) ? vecs[v].d1 : vecs[v].d0,
                vecs[v].exp_cnt, 1'b0, 0, waited);
    end

    // Both requesters continuously valid: back-to-back alternating grants.
    bus.req_valid = 2'b11;
    bus.req_data  = {8'b0110_0000, 8'hFF};
    for (int g = 0; g < 4; g++) begin
      run_frame($sformatf("alt%0d", g), g % 2, (g % 2 == 1) ? 8'b0110_0000 : 8'hFF,
                g % 2, 1'b1, 0, waited);
      chk($sformatf("alt%0d_b2b", g), 32'(waited), 0);
    end
    bus.req_valid = 2'b00;

    // Response held off for five cycles.
    bus.req_valid = 2'b01;
    bus.req_data  = {8'h00, 8'b1101_1000};
    bus.rsp_ready = 1'b0;
    run_frame("stall", 0, 8'b1101_1000, 2, 1'b0, 5, waited);

    // Reset during SHIFT index 3 aborts the frame.
    bus.req_valid = 2'b01;
    bus.req_data  = {8'h00, 8'b1101_1000};
    #1;
    waited = 0;
    while (bus.req_ready == 2'b00 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("abort_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort_idx3_bit", 32'(det_bit), 1);
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("abort_rst_det_rst", 32'(det_rst), 1);
    chk("abort_rst_req_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.req_valid = 2'b00;
    #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_rsp_count", 32'(bus.rsp_count), 0);
    chk("abort_det_bit", 32'(det_bit), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_no_rsp%0d", c), 32'(bus.rsp_valid), 0);
    end
    bus.req_valid = 2'b11;
    bus.req_data  = {8'hFF, 8'b1101_1011};
    run_frame("after_abort", 0, 8'b1101_1011, 2, 1'b0, 0, waited);
    chk("after_abort_wait", 32'(waited), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
